// File: rtl/mac_rx_pkg.sv
// ----------------------------------------------------------------------------
// mac_rx_pkg : shared types and constants for the GMII receive frame parser
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package mac_rx_pkg;

  typedef enum logic [2:0] {
    ST_WAIT_IDLE = 3'd0,
    ST_IDLE      = 3'd1,
    ST_PREAMBLE  = 3'd2,
    ST_DATA      = 3'd3,
    ST_DROP      = 3'd4
  } rx_state_e;

  localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

  localparam logic [15:0] MIN_FRAME = 16'd64;
  localparam logic [7:0]  SFD       = 8'hD5;
  localparam logic [7:0]  PRE       = 8'h55;
  localparam logic [3:0]  MAX_PRE   = 4'd15;

  // Byte idx of a MAC address in wire order (idx 0 is the first byte on the line).
  function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [2:0] idx);
    logic [7:0] b;
    b = 8'h00;
    for (int i = 0; i < 6; i++) begin
      if (idx == 3'(i)) b = mac[8*(5-i) +: 8];
    end
    return b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mac_rx_frame_crc32_d8.sv
// ----------------------------------------------------------------------------
// crc32_d8 : combinational reflected CRC-32 update over one byte (LSB first)
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module crc32_d8
  import mac_rx_pkg::*;
(
  input  logic [31:0] crc_i,
  input  logic [7:0]  data_i,
  output logic [31:0] crc_o
);

  logic [31:0] w_crc;

  always_comb begin
    w_crc = crc_i ^ {24'h000000, data_i};
    for (int i = 0; i < 8; i++) begin
      w_crc = w_crc[0] ? ((w_crc >> 1) ^ CRC_POLY) : (w_crc >> 1);
    end
    crc_o = w_crc;
  end

endmodule

`default_nettype wire

// File: rtl/mac_rx_frame.sv
// ----------------------------------------------------------------------------
// mac_rx_frame : GMII receive parser - strips preamble/SFD, streams DA..payload
//                without FCS, checks CRC/length/DA and issues a frame verdict
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mac_rx_frame
  import mac_rx_pkg::*;
#(
  parameter logic [47:0] LOCAL_MAC = 48'h000a3501fec0,
  parameter bit          CHECK_DA  = 1'b1,
  parameter int unsigned MAX_LEN   = 1518
) (
  input  logic        gmii_rx_clk,
  input  logic        reset,
  input  logic        gmii_rx_dv,
  input  logic [7:0]  gmii_rxd,
  input  logic        gmii_rx_er,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        rx_sof,
  output logic        rx_done,
  output logic        rx_good,
  output logic        rx_bad,
  output logic [15:0] frame_len,
  output logic [15:0] eth_type
);

  localparam logic [15:0] MAX_LEN_W = 16'(MAX_LEN);

  logic            dv_q;
  logic            er_q;
  logic [7:0]      rxd_q;
  rx_state_e       state_q, state_d;
  logic [3:0]      pre_cnt_q;
  logic [31:0]     crc_q;
  logic [31:0]     w_crc_next;
  logic [15:0]     cnt_q;
  logic [15:0]     w_cnt_inc;
  logic [3:0][7:0] dly_q;
  logic [2:0]      fill_q;
  logic            da_loc_q, da_bc_q;
  logic            er_flag_q, len_err_q, from_data_q, sof_pend_q;
  logic [7:0]      rx_data_q;
  logic            rx_valid_q, rx_sof_q, rx_done_q, rx_good_q, rx_bad_q;
  logic [15:0]     eth_type_q;

  logic w_pre_start, w_pre_inc, w_sfd, w_byte, w_len_err, w_done, w_good;

  crc32_d8 u_crc (
    .crc_i  (crc_q),
    .data_i (rxd_q),
    .crc_o  (w_crc_next)
  );

  assign w_cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

  assign w_good = (crc_q == CRC_RESIDUE) && (cnt_q >= MIN_FRAME) && (cnt_q <= MAX_LEN_W) &&
                  !er_flag_q && !len_err_q && (da_loc_q || da_bc_q || !CHECK_DA);

  // Input stage: every decision below works on the registered copy.
  always_ff @(posedge gmii_rx_clk) begin
    if (reset) begin
      dv_q  <= 1'b0;
      er_q  <= 1'b0;
      rxd_q <= 8'h00;
    end else begin
      dv_q  <= gmii_rx_dv;
      er_q  <= gmii_rx_er & gmii_rx_dv;
      rxd_q <= gmii_rxd;
    end
  end

  always_ff @(posedge gmii_rx_clk) begin
    if (reset) state_q <= ST_WAIT_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    w_pre_start = 1'b0;
    w_pre_inc   = 1'b0;
    w_sfd       = 1'b0;
    w_byte      = 1'b0;
    w_len_err   = 1'b0;
    w_done      = 1'b0;
    case (state_q)
      // Raw dv here, so a frame still running at reset release is never parsed.
      ST_WAIT_IDLE: begin
        if (!gmii_rx_dv) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (dv_q) begin
          if (rxd_q == PRE) begin
            state_d     = ST_PREAMBLE;
            w_pre_start = 1'b1;
          end else begin
            state_d = ST_DROP;
          end
        end
      end
      ST_PREAMBLE: begin
        if (!dv_q) begin
          state_d = ST_IDLE;
        end else if (rxd_q == PRE) begin
          w_pre_inc = 1'b1;
          if (pre_cnt_q + 4'd1 == MAX_PRE) state_d = ST_DROP;
        end else if (rxd_q == SFD) begin
          state_d = ST_DATA;
          w_sfd   = 1'b1;
        end else begin
          state_d = ST_DROP;
        end
      end
      ST_DATA: begin
        if (!dv_q) begin
          state_d = ST_IDLE;
          w_done  = 1'b1;
        end else if (cnt_q >= MAX_LEN_W) begin
          state_d   = ST_DROP;
          w_len_err = 1'b1;
        end else begin
          w_byte = 1'b1;
        end
      end
      ST_DROP: begin
        if (!dv_q) begin
          state_d = ST_IDLE;
          w_done  = from_data_q;
        end
      end
      default: state_d = ST_WAIT_IDLE;
    endcase
  end

  always_ff @(posedge gmii_rx_clk) begin
    if (reset) begin
      pre_cnt_q   <= 4'd0;
      crc_q       <= 32'h00000000;
      cnt_q       <= 16'd0;
      dly_q       <= '0;
      fill_q      <= 3'd0;
      da_loc_q    <= 1'b0;
      da_bc_q     <= 1'b0;
      er_flag_q   <= 1'b0;
      len_err_q   <= 1'b0;
      from_data_q <= 1'b0;
      sof_pend_q  <= 1'b0;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      rx_sof_q    <= 1'b0;
      rx_done_q   <= 1'b0;
      rx_good_q   <= 1'b0;
      rx_bad_q    <= 1'b0;
      eth_type_q  <= 16'h0000;
    end else begin
      rx_valid_q <= 1'b0;
      rx_sof_q   <= 1'b0;
      rx_done_q  <= 1'b0;
      rx_good_q  <= 1'b0;
      rx_bad_q   <= 1'b0;

      if (w_pre_start) pre_cnt_q <= 4'd1;
      if (w_pre_inc)   pre_cnt_q <= pre_cnt_q + 4'd1;

      if (w_sfd) begin
        crc_q      <= CRC_INIT;
        cnt_q      <= 16'd0;
        dly_q      <= '0;
        fill_q     <= 3'd0;
        da_loc_q   <= 1'b1;
        da_bc_q    <= 1'b1;
        er_flag_q  <= 1'b0;
        len_err_q  <= 1'b0;
        sof_pend_q <= 1'b1;
        eth_type_q <= 16'h0000;
      end

      if (w_byte) begin
        crc_q <= w_crc_next;
        cnt_q <= w_cnt_inc;
        dly_q <= {rxd_q, dly_q[3:1]};
        // The last four bytes in the delay line are the FCS and never leave it.
        if (fill_q == 3'd4) begin
          rx_data_q  <= dly_q[0];
          rx_valid_q <= 1'b1;
          rx_sof_q   <= sof_pend_q;
          sof_pend_q <= 1'b0;
        end else begin
          fill_q <= fill_q + 3'd1;
        end
        if (cnt_q < 16'd6) begin
          if (rxd_q != mac_byte(LOCAL_MAC, cnt_q[2:0])) da_loc_q <= 1'b0;
          if (rxd_q != 8'hFF)                           da_bc_q  <= 1'b0;
        end
        if (cnt_q == 16'd12) eth_type_q[15:8] <= rxd_q;
        if (cnt_q == 16'd13) eth_type_q[7:0]  <= rxd_q;
        if (er_q) er_flag_q <= 1'b1;
      end

      if (w_len_err) begin
        cnt_q       <= w_cnt_inc;
        len_err_q   <= 1'b1;
        from_data_q <= 1'b1;
      end

      if (w_done) begin
        rx_done_q   <= 1'b1;
        rx_good_q   <= w_good;
        rx_bad_q    <= !w_good;
        from_data_q <= 1'b0;
      end
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign rx_sof    = rx_sof_q;
  assign rx_done   = rx_done_q;
  assign rx_good   = rx_good_q;
  assign rx_bad    = rx_bad_q;
  assign frame_len = cnt_q;
  assign eth_type  = eth_type_q;

endmodule

`default_nettype wire

// File: tb/tb_mac_rx_frame.sv
// ----------------------------------------------------------------------------
// tb_mac_rx_frame : directed + randomized frames against a frame-level model
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_mac_rx_frame;

  localparam logic [47:0] MAC   = 48'h000a3501fec0;
  localparam logic [47:0] BCAST = 48'hFFFFFFFFFFFF;
  localparam logic [47:0] OTHER = 48'h001122334455;
  localparam int          MAXL  = 1518;

  typedef byte unsigned bq_t[$];

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic        dv    = 1'b0;
  logic        er    = 1'b0;
  logic [7:0]  rxd   = 8'h00;

  logic [7:0]  rx_data, n_rx_data;
  logic        rx_valid, rx_sof, rx_done, rx_good, rx_bad;
  logic        n_rx_valid, n_rx_sof, n_rx_done, n_rx_good, n_rx_bad;
  logic [15:0] frame_len, eth_type, n_frame_len, n_eth_type;

  mac_rx_frame #(.LOCAL_MAC(MAC), .CHECK_DA(1'b1), .MAX_LEN(MAXL)) dut (
    .gmii_rx_clk(clk), .reset(reset), .gmii_rx_dv(dv), .gmii_rxd(rxd), .gmii_rx_er(er),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_sof(rx_sof), .rx_done(rx_done),
    .rx_good(rx_good), .rx_bad(rx_bad), .frame_len(frame_len), .eth_type(eth_type)
  );

  mac_rx_frame #(.LOCAL_MAC(MAC), .CHECK_DA(1'b0), .MAX_LEN(MAXL)) dut_nda (
    .gmii_rx_clk(clk), .reset(reset), .gmii_rx_dv(dv), .gmii_rxd(rxd), .gmii_rx_er(er),
    .rx_data(n_rx_data), .rx_valid(n_rx_valid), .rx_sof(n_rx_sof), .rx_done(n_rx_done),
    .rx_good(n_rx_good), .rx_bad(n_rx_bad), .frame_len(n_frame_len), .eth_type(n_eth_type)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  byte unsigned got_bytes[$], exp_stream[$];
  int           got_sof[$], exp_sof[$];
  logic [1:0]   got_verd[$], exp_verd[$];
  logic [15:0]  got_len[$], exp_len[$], got_type[$], exp_type[$];
  logic         got_nda[$], exp_nda[$];
  int           valid_in_done = 0;
  int           stray_sof     = 0;

  always @(negedge clk) begin
    if (!reset) begin
      if (rx_valid) begin
        if (rx_sof) got_sof.push_back(got_bytes.size());
        got_bytes.push_back(rx_data);
      end
      if (rx_sof && !rx_valid) stray_sof++;
      if (rx_done) begin
        got_verd.push_back({rx_good, rx_bad});
        got_len.push_back(frame_len);
        got_type.push_back(eth_type);
        if (rx_valid) valid_in_done++;
      end
      if (n_rx_done) got_nda.push_back(n_rx_good && !n_rx_bad);
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic d_v, input logic [7:0] d, input logic e);
    @(negedge clk);
    dv  = d_v;
    rxd = d;
    er  = e;
  endtask

  function automatic logic [31:0] crc_calc(input bq_t b);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (b[i]) begin
      c = c ^ {24'h0, b[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  // DA, random SA, type, random payload, then FCS; optionally corrupt one payload bit.
  function automatic bq_t build(input logic [47:0] da, input logic [15:0] typ,
                                input int plen, input bit corrupt);
    bq_t b;
    logic [31:0] fcs;
    for (int i = 0; i < 6; i++) b.push_back(da[8*(5-i) +: 8]);
    for (int i = 0; i < 6; i++) b.push_back(8'($urandom));
    b.push_back(typ[15:8]);
    b.push_back(typ[7:0]);
    for (int i = 0; i < plen; i++) b.push_back(8'($urandom));
    fcs = ~crc_calc(b);
    for (int i = 0; i < 4; i++) b.push_back(fcs[8*i +: 8]);
    if (corrupt) b[20] = b[20] ^ 8'h04;
    return b;
  endfunction

  // Frame-level expectation from the receive rules.
  function automatic void model(input bq_t b, input bit fcs_ok, input bit er_inj);
    int          n, nout;
    logic [47:0] da;
    bit          da_ok, base_ok;
    logic [15:0] t;
    n    = b.size();
    nout = (n > MAXL) ? MAXL - 4 : ((n > 4) ? n - 4 : 0);
    if (nout > 0) exp_sof.push_back(exp_stream.size());
    for (int i = 0; i < nout; i++) exp_stream.push_back(b[i]);
    da = '0;
    if (n >= 6) for (int i = 0; i < 6; i++) da = {da[39:0], b[i]};
    da_ok   = (n >= 6) && (da == MAC || da == BCAST);
    base_ok = fcs_ok && !er_inj && n >= 64 && n <= MAXL;
    exp_verd.push_back((base_ok && da_ok) ? 2'b10 : 2'b01);
    exp_nda.push_back(base_ok);
    exp_len.push_back((n > MAXL) ? 16'(MAXL + 1) : 16'(n));
    t = 16'h0000;
    if (n >= 13) t[15:8] = b[12];
    if (n >= 14) t[7:0]  = b[13];
    exp_type.push_back(t);
  endfunction

  task automatic send(input bq_t b, input int npre, input int er_idx);
    for (int i = 0; i < npre; i++) drive(1'b1, 8'h55, 1'b0);
    drive(1'b1, 8'hD5, 1'b0);
    foreach (b[i]) drive(1'b1, b[i], (i == er_idx));
    // Error asserted while dv is low must have no effect.
    drive(1'b0, 8'($urandom), 1'b1);
  endtask

  task automatic check_all(input string tag);
    int nf, nmin, mism;
    nf = exp_verd.size();
    for (int w = 0; w < 40 && got_verd.size() < nf; w++) @(negedge clk);
    repeat (6) @(negedge clk);
    check($sformatf("%s_done_count", tag), got_verd.size(), nf);
    check($sformatf("%s_nda_done_count", tag), got_nda.size(), exp_nda.size());
    check($sformatf("%s_byte_count", tag), got_bytes.size(), exp_stream.size());
    mism = 0;
    nmin = (got_bytes.size() < exp_stream.size()) ? got_bytes.size() : exp_stream.size();
    for (int i = 0; i < nmin; i++) if (got_bytes[i] !== exp_stream[i]) mism++;
    check($sformatf("%s_byte_mismatches", tag), mism, 0);
    check($sformatf("%s_sof_count", tag), got_sof.size(), exp_sof.size());
    for (int i = 0; i < got_sof.size() && i < exp_sof.size(); i++)
      check($sformatf("%s_sof_pos%0d", tag, i), got_sof[i], exp_sof[i]);
    for (int i = 0; i < got_verd.size() && i < nf; i++) begin
      check($sformatf("%s_verdict%0d", tag, i), got_verd[i], exp_verd[i]);
      check($sformatf("%s_frame_len%0d", tag, i), got_len[i], exp_len[i]);
      check($sformatf("%s_eth_type%0d", tag, i), got_type[i], exp_type[i]);
    end
    for (int i = 0; i < got_nda.size() && i < exp_nda.size(); i++)
      check($sformatf("%s_nda_good%0d", tag, i), got_nda[i], exp_nda[i]);
    check($sformatf("%s_valid_in_done", tag), valid_in_done, 0);
    check($sformatf("%s_stray_sof", tag), stray_sof, 0);
    got_bytes.delete(); exp_stream.delete(); got_sof.delete(); exp_sof.delete();
    got_verd.delete(); exp_verd.delete(); got_len.delete(); exp_len.delete();
    got_type.delete(); exp_type.delete(); got_nda.delete(); exp_nda.delete();
    valid_in_done = 0;
    stray_sof     = 0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check($sformatf("%s_ctrl", tag), {rx_data, rx_valid, rx_sof, rx_done, rx_good, rx_bad}, 32'h0);
    check($sformatf("%s_len_type", tag), {frame_len, eth_type}, 32'h0);
  endtask

  initial begin
    bq_t f, g;
    int  er_idx, sel, plen;
    bit  corrupt;
    logic [47:0] da;

    reset = 1'b1;
    repeat (4) drive(1'b0, 8'h00, 1'b0);
    check_outputs_zero("reset");
    reset = 1'b0;
    repeat (3) drive(1'b0, 8'h00, 1'b0);

    f = build(MAC, 16'h0800, 46, 1'b0);   model(f, 1'b1, 1'b0); send(f, 7, -1);  check_all("good");
    f = build(MAC, 16'h0800, 46, 1'b1);   model(f, 1'b0, 1'b0); send(f, 7, -1);  check_all("bad_fcs");
    f = build(OTHER, 16'h0800, 46, 1'b0); model(f, 1'b1, 1'b0); send(f, 7, -1);  check_all("da_other");
    f = build(BCAST, 16'h0806, 46, 1'b0); model(f, 1'b1, 1'b0); send(f, 7, -1);  check_all("bcast");
    f = build(MAC, 16'h0800, 80, 1'b0);   model(f, 1'b1, 1'b1); send(f, 7, 30);  check_all("rx_er");
    f = build(MAC, 16'h0800, 1582, 1'b0); model(f, 1'b1, 1'b0); send(f, 7, -1);  check_all("too_long");
    f = build(MAC, 16'h86DD, 1500, 1'b0); model(f, 1'b1, 1'b0); send(f, 7, -1);  check_all("max_len");
    f = build(MAC, 16'h0800, 45, 1'b0);   model(f, 1'b1, 1'b0); send(f, 7, -1);  check_all("len63");

    f = {8'h00, 8'h0a, 8'h35};
    model(f, 1'b0, 1'b0); send(f, 7, -1); check_all("short3");

    f = build(MAC, 16'h0800, $urandom_range(46, 200), 1'b0);
    g = build(BCAST, 16'h0800, $urandom_range(46, 200), 1'b0);
    model(f, 1'b1, 1'b0); model(g, 1'b1, 1'b0);
    send(f, 7, -1); send(g, 7, -1);
    check_all("back2back");

    drive(1'b1, 8'h55, 1'b0); drive(1'b1, 8'h55, 1'b0); drive(1'b1, 8'hA5, 1'b0);
    for (int i = 0; i < 20; i++) drive(1'b1, 8'($urandom), 1'b0);
    drive(1'b0, 8'h00, 1'b0);
    check_all("bad_preamble");

    f = build(MAC, 16'h0800, 46, 1'b0); send(f, 15, -1); check_all("pre15");
    f = build(MAC, 16'h0800, 46, 1'b0); model(f, 1'b1, 1'b0); send(f, 14, -1); check_all("pre14");
    f = build(MAC, 16'h0800, 46, 1'b0); model(f, 1'b1, 1'b0); send(f, 1, -1);  check_all("pre1");

    for (int r = 0; r < 8; r++) begin
      sel     = $urandom_range(0, 2);
      da      = (sel == 0) ? MAC : ((sel == 1) ? BCAST : OTHER);
      plen    = $urandom_range(40, 120);
      corrupt = ($urandom_range(0, 3) == 0);
      f       = build(da, 16'($urandom), plen, corrupt);
      er_idx  = ($urandom_range(0, 4) == 0) ? $urandom_range(0, f.size() - 1) : -1;
      model(f, !corrupt, er_idx >= 0);
      send(f, $urandom_range(1, 14), er_idx);
      check_all($sformatf("rand%0d", r));
    end

    f = build(MAC, 16'h0800, 100, 1'b0);
    for (int i = 0; i < 7; i++) drive(1'b1, 8'h55, 1'b0);
    drive(1'b1, 8'hD5, 1'b0);
    for (int i = 0; i < 20; i++) drive(1'b1, f[i], 1'b0);
    reset = 1'b1;
    drive(1'b1, f[20], 1'b0);
    check_outputs_zero("midreset");
    got_bytes.delete(); got_sof.delete(); got_verd.delete(); got_len.delete();
    got_type.delete(); got_nda.delete();
    drive(1'b1, f[21], 1'b0);
    drive(1'b1, f[22], 1'b0);
    reset = 1'b0;
    for (int i = 23; i < f.size(); i++) drive(1'b1, f[i], 1'b0);
    drive(1'b0, 8'h00, 1'b0);
    check_all("reset_tail");
    g = build(MAC, 16'h0800, 46, 1'b0); model(g, 1'b1, 1'b0); send(g, 7, -1); check_all("after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mac_rx_frame.md
# mac_rx_frame

GMII receive-side frame parser, the receiving end of the byte stream that the MAC test path transmits. Sits between the GMII-to-RGMII adapter's receive outputs (`gmii_rx_clk`, `gmii_rx_dv`, `gmii_rxd`, `gmii_rx_er`) and the IP/UDP receive logic. It performs four functions:
- strips preamble and SFD;
- streams header and payload bytes with the FCS removed;
- checks the CRC-32, the frame length and the destination MAC;
- reports a one-cycle good/bad verdict per frame.

## Interface
- `LOCAL_MAC`, 48'h000a3501fec0: station address. DA match = `LOCAL_MAC` or broadcast FF:FF:FF:FF:FF:FF.
- `CHECK_DA`, 1: if 0, DA mismatch does not make a frame bad.
- `MAX_LEN`, 1518: max frame length in bytes, DA through FCS inclusive.
- `gmii_rx_clk`  in  1  sole clock.
- `reset`  in  1  synchronous, active-high.
- `gmii_rx_dv`  in  1  receive data valid.
- `gmii_rxd`  in  8  receive byte.
- `gmii_rx_er`  in  1  receive error.
- `rx_data`  out  8  frame byte, DA onward, FCS excluded.
- `rx_valid`  out  1  `rx_data` qualifier.
- `rx_sof`  out  1  high with the first `rx_valid` of a frame.
- `rx_done`  out  1  one-cycle end-of-frame strobe.
- `rx_good`  out  1  with `rx_done`: frame accepted.
- `rx_bad`  out  1  with `rx_done`: frame rejected. Exactly one of `rx_good`/`rx_bad` is high per `rx_done`.
- `frame_len`  out  16  bytes after SFD, FCS included. Saturates at FFFF. Held from `rx_done` until the next SFD.
- `eth_type`  out  16  bytes 12–13. Held like `frame_len`.

## Operation
- **FSM states:** WAIT_IDLE, IDLE, PREAMBLE, DATA, DROP.
- **WAIT_IDLE** (entered on reset):
  - → IDLE when `gmii_rx_dv`=0 is sampled.
  - Frames already in progress at reset release are ignored.
- **IDLE:**
  - dv=1 and rxd=55 → PREAMBLE, preamble count = 1.
  - dv=1 with any other byte → DROP, no `rx_done`.
- **PREAMBLE:**
  - rxd=55: count++. Count reaching 15 → DROP.
  - rxd=D5 → DATA. Clear CRC to FFFFFFFF, byte count, delay line and error flags.
  - Any other byte → DROP.
  - dv=0 → IDLE.
  - No `rx_done` is issued from any of these exits.
- **DATA:**
  - Each byte updates CRC and the byte count, and shifts into a 4-deep delay line.
  - Once 4 bytes are held, each new byte pushes the oldest out on `rx_data` with `rx_valid`=1.
  - Bytes 0–5 are compared with the DA. Bytes 12–13 are captured into `eth_type`.
  - `gmii_rx_er`=1 sets a sticky error flag.
  - Byte count exceeding `MAX_LEN`: set the length error, stop `rx_valid`, → DROP.
  - dv=0 → IDLE and issue `rx_done`. The 4 bytes left in the delay line (the FCS) are discarded.
- **DROP:**
  - Waits for dv=0 → IDLE.
  - Issues `rx_done`/`rx_bad` only if entered from DATA.
- **Verdict:** `rx_good` = CRC residue ok AND 64 ≤ len ≤ `MAX_LEN` AND no er AND (DA match OR `CHECK_DA`=0).
- **CRC:**
  - Reflected CRC-32, polynomial EDB88320, LSB-first per byte, init FFFFFFFF.
  - Runs over all bytes after SFD including the FCS.
  - Good residue: register = DEBB20E3.
- **Short frames:** frames of 4 bytes or fewer produce no `rx_valid` but still get `rx_done` with `rx_bad`.

## Timing
- **Reset values:** all outputs reset to 0, including `frame_len` and `eth_type`.
- **Pipeline:** the input is registered one stage. Byte k (k=0 is the first byte after SFD) appears on `rx_data` in the cycle after byte k+4 is sampled. Latency = 5 edges.
- **`rx_valid`:** continuous for back-to-back frame bytes. It never asserts in the `rx_done` cycle of the same frame.
- **`rx_done`:** registered on the edge at which dv=0 is first sampled in DATA or DROP. It lasts one cycle, and `frame_len`/`eth_type`/verdict are valid in that same cycle.
- **Inter-frame gap:** the FSM is in IDLE at the `rx_done` edge. A 1-cycle dv-low gap is accepted, so the next preamble is sampled on the following edge.
- **Errors:** `gmii_rx_er` with dv=0 is ignored.

## Structure
- **Package `mac_rx_pkg`:**
  - state enum;
  - `CRC_POLY` EDB88320, `CRC_INIT` FFFFFFFF, `CRC_RESIDUE` DEBB20E3;
  - `MIN_FRAME` 64, `SFD` D5, `PRE` 55, `MAX_PRE` 15.
- **Sub-module `crc32_d8`:** combinational next-CRC from (crc[31:0], byte[7:0]). It is reused by the transmit-side FCS generator.

## Test plan
- **Good frame:** 7×55, D5, 60-byte frame to `LOCAL_MAC` type 0800 with correct FCS → 60 `rx_valid` bytes, `rx_sof` on byte 0, then `rx_done`+`rx_good`, `frame_len`=64, `eth_type`=0800.
- **Corrupted FCS:** same frame with one payload bit flipped → 60 bytes streamed, then `rx_done`+`rx_bad`.
- **Filtering:**
  - DA=00:11:22:33:44:55, `CHECK_DA`=1 → `rx_bad`.
  - Same frame with `CHECK_DA`=0 → `rx_good`.
  - Broadcast DA → `rx_good`.
- **Errors:**
  - `gmii_rx_er` pulse mid-payload → `rx_bad`.
  - 1600-byte frame → `rx_valid` stops after byte 1514, `rx_bad`, `frame_len`=1519.
- **Back-to-back and bad preamble:** two good frames with a 1-cycle dv gap → two `rx_done`+`rx_good`. Preamble 55 55 A5 → no `rx_valid`, no `rx_done`.
- **Reset mid-frame:** reset asserted during DATA, released with dv still high → outputs 0, tail ignored, next frame after dv low received good.
